// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the mac_unit systolic array: buffers one K-deep block
// loaded over valid/ready, then streams it to the array edge with lane i delayed i cycles.
module systolic_operand_feeder #(
  parameter int unsigned IP_SIZE = 8,
  parameter int unsigned N       = 4,
  parameter int unsigned K       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IP_SIZE-1:0] in_data,
  input  logic                 go,
  output logic                 out_valid,
  output logic [N*IP_SIZE-1:0] out_data,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned W      = N * IP_SIZE;
  localparam int unsigned LCW    = $clog2(K + 1);
  localparam int unsigned TCW    = $clog2(K + N);
  localparam int unsigned TCW1   = TCW + 1;
  localparam int unsigned KIW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned LAST_T = K + N - 2;
  localparam int unsigned END_T  = K + N - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FULL,
    ST_STREAM
  } state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [TCW-1:0]   t_q, t_d;
  logic [W-1:0]     buf_q [K];
  logic [W-1:0]     buf_d [K];
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [TCW-1:0]   t_sel;
  logic [W-1:0]     beat_c;

  // Skewed beat for index t_sel: lane i shows row t_sel-i while that row exists.
  always_comb begin
    logic [TCW:0] diff;
    diff   = '0;
    t_sel  = (state_q == ST_STREAM) ? t_q : '0;
    beat_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      diff = {1'b0, t_sel} - TCW1'(i);
      if (!diff[TCW] && (diff < TCW1'(K))) begin
        beat_c[i*IP_SIZE +: IP_SIZE] = buf_q[KIW'(diff)][i*IP_SIZE +: IP_SIZE];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    t_d         = t_q;
    buf_d       = buf_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          buf_d[KIW'(load_cnt_q)] = in_data;
          if (load_cnt_q == LCW'(K - 1)) begin
            state_d    = ST_FULL;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + LCW'(1);
          end
        end
      end
      ST_FULL: begin
        if (go) begin
          state_d     = ST_STREAM;
          out_valid_d = 1'b1;
          out_data_d  = beat_c;
          done_d      = (t_sel == TCW'(LAST_T));
          t_d         = t_sel + TCW'(1);
        end
      end
      ST_STREAM: begin
        // t_q indexes the beat to present after this edge; END_T means the last one has shown.
        if (t_q == TCW'(END_T)) begin
          state_d    = ST_IDLE;
          t_d        = '0;
          load_cnt_d = '0;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = beat_c;
          done_d      = (t_sel == TCW'(LAST_T));
          t_d         = t_sel + TCW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        t_d        = '0;
        load_cnt_d = '0;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      t_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      t_q         <= t_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Buffer contents are only read after a full reload, so they need no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: directed scenarios plus random traffic,
// every cycle compared with a beat-index reference model.
module tb_systolic_operand_feeder;

  localparam int IP   = 8;
  localparam int N    = 4;
  localparam int K    = 4;
  localparam int W    = N * IP;
  localparam int LAST = K + N - 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, done, busy;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  systolic_operand_feeder #(.IP_SIZE(IP), .N(N), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .go       (go),
    .out_valid(out_valid),
    .out_data (out_data),
    .done     (done),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: beats held, whether the block is complete, beat index on display (-1 none).
  int m_cnt  = 0;
  bit m_full = 1'b0;
  int m_t    = -1;
  int mbuf [K][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (m_t >= i && m_t < i + K) r[i*IP +: IP] = IP'(mbuf[m_t-i][i]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack_v(input int k, input int base, input int kmul);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*IP +: IP] = IP'(base + kmul * k + i);
    return r;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0; m_full = 1'b0; m_t = -1;
    end else if (m_t >= 0) begin
      if (m_t == LAST) begin m_t = -1; m_cnt = 0; end
      else m_t++;
    end else if (m_full) begin
      if (go) begin m_full = 1'b0; m_t = 0; end
    end else if (in_valid) begin
      for (int i = 0; i < N; i++) mbuf[m_cnt][i] = int'(in_data[i*IP +: IP]);
      m_cnt++;
      if (m_cnt == K) begin m_full = 1'b1; m_cnt = 0; end
    end
  endtask

  // One clock: advance model with the applied inputs, then compare all outputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("in_ready",  64'(in_ready),  64'(!m_full && m_t < 0));
    check("busy",      64'(busy),      64'(m_full || m_t >= 0));
    check("out_valid", 64'(out_valid), 64'(m_t >= 0));
    check("done",      64'(done),      64'(m_t == LAST));
    check("out_data",  64'(out_data),  64'(exp_data()));
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic g);
    rst = r; in_valid = v; in_data = d; go = g;
  endtask

  task automatic load_block(input int base, input int kmul);
    for (int k = 0; k < K; k++) begin
      drive(1'b0, 1'b1, pack_v(k, base, kmul), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  int nv, nd;

  initial begin
    // 1: reset held with in_valid and go asserted
    drive(1'b1, 1'b1, pack_v(0, 1, 10), 1'b1);
    step(); step();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy",  64'(busy),     64'd0);

    // 2/4: load with gaps, go in IDLE and on the final load edge, extra beat ignored
    for (int k = 0; k < K; k++) begin
      drive(1'b0, 1'b1, pack_v(k, 1, 10), (k == K - 1));
      step();
      if (k < K - 1) begin
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
      end
    end
    check("full_ready", 64'(in_ready),  64'd0);
    check("full_busy",  64'(busy),      64'd1);
    check("no_early",   64'(out_valid), 64'd0);
    drive(1'b0, 1'b1, {W{1'b1}}, 1'b0);
    step();

    // 3: stream with go held high throughout
    drive(1'b0, 1'b0, '0, 1'b1);
    nv = 0; nd = 0;
    for (int t = 0; t <= LAST; t++) begin
      step();
      nv += int'(out_valid);
      nd += int'(done);
      if (t == 0) check("beat_t0", 64'(out_data), 64'h00_00_00_01);
      if (t == 3) check("beat_t3", 64'(out_data), 64'h04_0D_16_1F);
      if (t == 6) check("beat_t6", 64'(out_data), 64'h22_00_00_00);
    end
    step();
    check("valid_cycles", 64'(nv), 64'd7);
    check("done_pulses",  64'(nd), 64'd1);
    check("end_ready",    64'(in_ready), 64'd1);
    check("end_data",     64'(out_data), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b0);
    step();

    // 5: reset at t=2, then fresh block
    load_block(200, 3);
    drive(1'b0, 1'b0, '0, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b0); step(); step();
    drive(1'b1, 1'b0, '0, 1'b0); step();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data",  64'(out_data),  64'd0);
    load_block(100, 1);
    drive(1'b0, 1'b0, '0, 1'b1); step();
    check("fresh_t0", 64'(out_data), 64'h00_00_00_64);
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int t = 1; t <= LAST + 1; t++) step();

    // 6: back-to-back block loaded the cycle in_ready returns
    load_block(50, 7);
    drive(1'b0, 1'b0, '0, 1'b1); step();
    drive(1'b0, 1'b0, '0, 1'b0);
    nd = int'(done);
    for (int t = 1; t <= LAST + 1; t++) begin
      step();
      nd += int'(done);
    end
    check("b2b_done", 64'(nd), 64'd1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 300) == 0, ($urandom % 3) != 0, W'($urandom), ($urandom % 4) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Upstream stage of the mac_unit systolic array.
- Buffers one K-deep operand block for N array lanes via a valid/ready load port.
- On command, streams the block into the array edge with diagonal skew: lane i is delayed i cycles, and zeros fill the unused slots.
- One instance feeds the x edge and one feeds the w edge; a shared go pulse keeps them aligned.

Parameters:
- IP_SIZE, 8, operand width per lane; matches the mac_unit x/w width.
- N, 4, number of array lanes (rows or columns of the array).
- K, 4, block depth (inner dimension); beats loaded and elements per lane streamed.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  load beat valid.
- in_ready  output  1  feeder can accept a load beat.
- in_data  input  N*IP_SIZE  one beat: element k for all lanes; lane i = bits [i*IP_SIZE +: IP_SIZE].
- go  input  1  start streaming; honoured only in FULL.
- out_valid  output  1  out_data is a live skewed beat.
- out_data  output  N*IP_SIZE  skewed lane values driven to the array x_new/w_new inputs; same packing as in_data.
- done  output  1  one-cycle pulse coincident with the last streamed beat.
- busy  output  1  high in FULL and STREAM.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; load count and stream count cleared; buffer contents treated as discarded.
  - Outputs: in_ready=1, out_valid=0, out_data=0, done=0, busy=0.
  - Reset wins over every other input in the same cycle, including mid-STREAM.
- States: IDLE (loading), FULL, STREAM.
- IDLE:
  - in_ready=1.
  - Each edge with in_valid=1 writes in_data into buffer row k (k = load count) and increments k.
  - On the edge accepting beat K-1 → FULL; in_ready=0 from the next cycle.
  - go is ignored in IDLE, including on the edge of the final load beat.
- FULL:
  - in_ready=0; in_valid ignored.
  - Waits for go; the edge sampling go=1 → STREAM with t=0.
- STREAM:
  - Lasts K+N-1 cycles, t=0..K+N-2.
  - Outputs are registered: beat t appears in the t-th cycle after the go edge (first beat in the cycle immediately following it).
  - Lane i value = buf[t-i][i] when i <= t < i+K, else 0.
  - out_valid=1 for all K+N-1 beats; done=1 only on beat t=K+N-2.
  - The edge ending the last beat → IDLE: load count cleared, in_ready=1, out_valid=0, out_data=0 from the next cycle.
  - go and in_valid are ignored throughout STREAM.
- Outside STREAM, out_data is forced to 0 so the downstream MACs accumulate nothing.
- Counters:
  - Load count width clog2(K+1); stream count width clog2(K+N).
  - No wrap: both are cleared on state exit.
- No arithmetic on data; values pass bit-exact.
- Single buffer: loading and streaming never overlap.

Test Plan:
Default parameters (N=4, K=4, IP_SIZE=8); load value v(k,i) = 10k+i+1.

1. Reset:
   - Hold rst 2 cycles with in_valid=1 and go=1 → in_ready=1, out_valid=0, out_data=0, done=0, busy=0; no load accepted.
2. Load and backpressure:
   - Present 4 beats with in_valid gaps → exactly 4 beats accepted; in_ready falls the cycle after beat 3; busy=1.
   - A fifth in_valid beat is ignored.
3. Skewed stream after go:
   - t=0 → lanes {1,0,0,0}
   - t=3 → {31,22,13,4}
   - t=6 → {0,0,0,34}
   - out_valid high exactly 7 cycles; done high only at t=6.
   - in_ready=1 and out_data=0 in the following cycle.
4. go timing:
   - go during IDLE, or on the same edge as the last load beat → no stream.
   - go one cycle later → stream starts next cycle.
   - go held high during STREAM → no restart.
5. Reset mid-operation:
   - rst at t=2 → next cycle out_valid=0, out_data=0, state IDLE.
   - A fresh load of v'(k,i) = 100+k+i followed by go → lane0 beat t=0 is 100; no stale values appear.
6. Back-to-back blocks:
   - Second load starts the cycle in_ready returns; second go streams correct values.
   - Exactly one done pulse per block.
